// File: rtl/uart_tx.sv
// UART transmitter: start bit, PAYLOAD_BITS data bits LSB first, optional parity, STOP_BITS stop bits.
// Line, busy and debug outputs are all registered; the line idles high.
module uart_tx #(
  parameter int BIT_RATE     = 12_500_000,
  parameter int CLK_HZ       = 50_000_000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY       = 0
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_tx_en,
  input  logic [PAYLOAD_BITS-1:0] uart_tx_data,
  output logic                    uart_tx_busy,
  output logic                    uart_txd,
  output logic [15:0]             counter,
  output logic [2:0]              fsm
);

  localparam int BIT_P = 1_000_000_000 / BIT_RATE;
  localparam int CLK_P = 1_000_000_000 / CLK_HZ;
  localparam int CPB   = BIT_P / CLK_P;

  localparam logic [15:0] CPB_LAST  = 16'(CPB - 1);
  localparam logic [3:0]  LAST_BIT  = 4'(PAYLOAD_BITS - 1);
  localparam logic        STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                  state;
  logic [15:0]             cycle_counter;
  logic [3:0]              bit_counter;
  logic                    stop_counter;
  logic [PAYLOAD_BITS-1:0] shift_reg;
  logic [PAYLOAD_BITS-1:0] shift_next;
  logic                    parity_bit;
  logic                    bit_done;

  assign bit_done = (cycle_counter == CPB_LAST);
  assign counter  = cycle_counter;
  assign fsm      = state;

  always_comb begin
    shift_next = shift_reg >> 1;
  end

  // uart_txd is loaded with the level of the state being entered, so each bit
  // appears on the line in the same cycle the state changes.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= S_IDLE;
      cycle_counter <= 16'd0;
      bit_counter   <= 4'd0;
      stop_counter  <= 1'b0;
      shift_reg     <= '0;
      parity_bit    <= 1'b0;
      uart_txd      <= 1'b1;
      uart_tx_busy  <= 1'b0;
    end else begin
      if (state == S_IDLE || bit_done) cycle_counter <= 16'd0;
      else                             cycle_counter <= cycle_counter + 16'd1;

      case (state)
        S_IDLE: begin
          bit_counter  <= 4'd0;
          stop_counter <= 1'b0;
          uart_txd     <= 1'b1;
          uart_tx_busy <= 1'b0;
          if (uart_tx_en) begin
            shift_reg    <= uart_tx_data;
            parity_bit   <= (PARITY == 1) ? ~^uart_tx_data : ^uart_tx_data;
            state        <= S_START;
            uart_txd     <= 1'b0;
            uart_tx_busy <= 1'b1;
          end
        end
        S_START: begin
          bit_counter  <= 4'd0;
          stop_counter <= 1'b0;
          if (bit_done) begin
            state    <= S_DATA;
            uart_txd <= shift_reg[0];
          end
        end
        S_DATA: begin
          stop_counter <= 1'b0;
          if (bit_done) begin
            shift_reg <= shift_next;
            if (bit_counter == LAST_BIT) begin
              bit_counter <= 4'd0;
              if (PARITY != 0) begin
                state    <= S_PARITY;
                uart_txd <= parity_bit;
              end else begin
                state    <= S_STOP;
                uart_txd <= 1'b1;
              end
            end else begin
              bit_counter <= bit_counter + 4'd1;
              uart_txd    <= shift_next[0];
            end
          end
        end
        S_PARITY: begin
          bit_counter  <= 4'd0;
          stop_counter <= 1'b0;
          if (bit_done) begin
            state    <= S_STOP;
            uart_txd <= 1'b1;
          end
        end
        S_STOP: begin
          bit_counter <= 4'd0;
          uart_txd    <= 1'b1;
          if (bit_done) begin
            if (stop_counter == STOP_LAST) begin
              state        <= S_IDLE;
              stop_counter <= 1'b0;
              uart_tx_busy <= 1'b0;
            end else begin
              stop_counter <= 1'b1;
            end
          end
        end
        default: begin
          state        <= S_IDLE;
          bit_counter  <= 4'd0;
          stop_counter <= 1'b0;
          uart_txd     <= 1'b1;
          uart_tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances (default, even parity, odd parity, two stop bits)
// checked every cycle against a queue-of-line-levels model plus literal frame checks.
module tb_uart_tx;

  localparam int N   = 4;
  localparam int CPB = (1_000_000_000 / 12_500_000) / (1_000_000_000 / 50_000_000);
  localparam int PAR_CFG  [N] = '{0, 2, 1, 0};
  localparam int STOP_CFG [N] = '{1, 1, 1, 2};
  localparam logic [19:0] IDLE_WORD = {16'd0, 3'd0, 1'b1};

  logic        clk;
  logic        resetn;
  logic        en   [N];
  logic [7:0]  data [N];
  logic        busy [N];
  logic        txd  [N];
  logic [15:0] cnt  [N];
  logic [2:0]  fsm  [N];

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    uart_tx #(
      .BIT_RATE    (12_500_000),
      .CLK_HZ      (50_000_000),
      .PAYLOAD_BITS(8),
      .STOP_BITS   (STOP_CFG[g]),
      .PARITY      (PAR_CFG[g])
    ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .uart_tx_en  (en[g]),
      .uart_tx_data(data[g]),
      .uart_tx_busy(busy[g]),
      .uart_txd    (txd[g]),
      .counter     (cnt[g]),
      .fsm         (fsm[g])
    );
  end

  // ---------------- model: one queue entry {counter, fsm, txd} per line cycle ----------------
  logic [19:0] exp_q [N][$];
  logic [19:0] exp_out  [N];
  logic        exp_busy [N];
  logic        model_live = 1'b0;

  task automatic push_frame(input int i, input logic [7:0] d);
    logic [9:0] lvl [$];
    logic [2:0] st  [$];
    lvl.push_back(1'b0); st.push_back(3'd1);
    for (int b = 0; b < 8; b++) begin lvl.push_back(d[b]); st.push_back(3'd2); end
    if (PAR_CFG[i] == 2) begin lvl.push_back(^d);  st.push_back(3'd3); end
    if (PAR_CFG[i] == 1) begin lvl.push_back(~^d); st.push_back(3'd3); end
    for (int s = 0; s < STOP_CFG[i]; s++) begin lvl.push_back(1'b1); st.push_back(3'd4); end
    foreach (lvl[k])
      for (int c = 0; c < CPB; c++) exp_q[i].push_back({16'(c), st[k], lvl[k][0]});
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!resetn) begin
        exp_q[i].delete();
        exp_out[i]  = IDLE_WORD;
        exp_busy[i] = 1'b0;
      end else begin
        if (!exp_busy[i] && en[i]) push_frame(i, data[i]);
        if (exp_q[i].size() > 0) begin
          exp_out[i]  = exp_q[i].pop_front();
          exp_busy[i] = 1'b1;
        end else begin
          exp_out[i]  = IDLE_WORD;
          exp_busy[i] = 1'b0;
        end
      end
    end
    if (!resetn) model_live = 1'b1;
  end

  // ---------------- scoreboard compare, every cycle on the falling edge ----------------
  always @(negedge clk) begin
    if (model_live) begin
      for (int i = 0; i < N; i++) begin
        checks++;
        if (txd[i] !== exp_out[i][0]) begin
          errors++;
          $display("FAIL txd[%0d] t=%0t got %b exp %b", i, $time, txd[i], exp_out[i][0]);
        end
        checks++;
        if (busy[i] !== exp_busy[i]) begin
          errors++;
          $display("FAIL busy[%0d] t=%0t got %b exp %b", i, $time, busy[i], exp_busy[i]);
        end
        checks++;
        if (fsm[i] !== exp_out[i][3:1]) begin
          errors++;
          $display("FAIL fsm[%0d] t=%0t got %0d exp %0d", i, $time, fsm[i], exp_out[i][3:1]);
        end
        checks++;
        if (cnt[i] !== exp_out[i][19:4]) begin
          errors++;
          $display("FAIL counter[%0d] t=%0t got %0d exp %0d", i, $time, cnt[i], exp_out[i][19:4]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h exp 0x%0h", name, got, exp);
    end
  endtask

  // Send one word, sample each bit mid-period, optionally pulse a new request mid-frame.
  task automatic send_frame(input int i, input logic [7:0] d, input int exp_len,
                            input logic [11:0] exp_bits, input int disturb_at, input string name);
    int n;
    logic [11:0] got;
    logic [11:0] mask;
    got = '0;
    n = 0;
    @(negedge clk); en[i] = 1'b1; data[i] = d;
    @(negedge clk); en[i] = 1'b0; data[i] = 8'h00;
    while (busy[i] && n < 200) begin
      if (n % CPB == 1 && n / CPB < 12) got[n / CPB] = txd[i];
      if (n == disturb_at) en[i] = 1'b1;
      else                 en[i] = 1'b0;
      n++;
      @(negedge clk);
    end
    en[i] = 1'b0;
    mask = 12'((1 << (exp_len / CPB)) - 1);
    check({name, " length"}, n, exp_len);
    check({name, " bits"}, int'(got & mask), int'(exp_bits));
    repeat (3) @(negedge clk);
  endtask

  task automatic back_to_back();
    int run;
    int period;
    logic found;
    run = 0; period = 0; found = 1'b0;
    @(negedge clk); en[0] = 1'b1; data[0] = 8'h12;
    @(negedge clk); data[0] = 8'h34;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clk);
      if (fsm[0] == 3'd1 && cnt[0] == 16'd0) begin
        found = 1'b1;
        en[0] = 1'b0;
        period = n + 1;
      end else if (txd[0]) run++;
      else run = 0;
    end
    check("b2b second start seen", int'(found), 1);
    check("b2b high gap", run, 5);
    check("b2b start period", period, 41);
    for (int n = 0; n < 100 && busy[0]; n++) @(negedge clk);
    check("b2b frame2 ends", int'(busy[0]), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic reset_mid_frame();
    @(negedge clk); en[0] = 1'b1; data[0] = 8'hC3;
    @(negedge clk); en[0] = 1'b0;
    repeat (17) @(negedge clk);
    resetn = 1'b0;
    en[1] = 1'b1; data[1] = 8'hFF;
    @(negedge clk);
    check("rst txd", int'(txd[0]), 1);
    check("rst busy", int'(busy[0]), 0);
    check("rst fsm", int'(fsm[0]), 0);
    check("rst counter", int'(cnt[0]), 0);
    resetn = 1'b1;
    en[1] = 1'b0;
    @(negedge clk);
    check("rst request dropped", int'(busy[1]), 0);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    resetn = 1'b0;
    for (int i = 0; i < N; i++) begin en[i] = 1'b0; data[i] = 8'h00; end
    repeat (3) @(negedge clk);
    check("reset txd", int'(txd[0]), 1);
    check("reset busy", int'(busy[0]), 0);
    check("reset fsm", int'(fsm[0]), 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    send_frame(0, 8'hA5, 40, 12'h34A, -1, "default A5");
    send_frame(1, 8'h07, 44, 12'h60E, -1, "even parity 07");
    send_frame(2, 8'h07, 44, 12'h40E, -1, "odd parity 07");
    send_frame(3, 8'hFF, 44, 12'h7FE, -1, "two stop FF");
    back_to_back();
    send_frame(0, 8'h3C, 40, 12'h278, 10, "ignore while busy 3C");
    check("no extra frame", int'(busy[0]), 0);
    reset_mid_frame();
    send_frame(0, 8'h5A, 40, 12'h2B4, -1, "after reset 5A");

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter. It serialises one PAYLOAD_BITS word per request onto uart_txd. Frame format is start bit, data LSB-first, optional parity bit, then STOP_BITS stop bits. It is the transmit-side partner of the UART receiver and uses the same bit-timing parameters, so a tx→rx loopback works with default parameters.

Parameters:
BIT_RATE, 12_500_000, line bit rate in bits/s.
CLK_HZ, 50_000_000, clk frequency in Hz.
PAYLOAD_BITS, 8, data bits per frame (1..15).
STOP_BITS, 1, number of stop bits (1 or 2).
PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.

Ports:
clk  input  1  system clock; all logic is posedge.
resetn  input  1  reset, synchronous, active-low.
uart_tx_en  input  1  send request; accepted when sampled high while uart_tx_busy is low.
uart_tx_data  input  PAYLOAD_BITS  word to send; sampled only on acceptance.
uart_tx_busy  output  1  high while a frame is in progress.
uart_txd  output  1  serial line, registered, idles high.
counter  output  16  debug: current bit-period cycle counter.
fsm  output  3  debug: current FSM state.

Behaviour:
- Bit timing:
  - BIT_P = 1e9/BIT_RATE, CLK_P = 1e9/CLK_HZ, CYCLES_PER_BIT (CPB) = BIT_P/CLK_P, all integer division.
  - Defaults give CPB = 4.
  - cycle_counter is 16 bits. It counts 0..CPB-1 within each bit period, then returns to 0.
- FSM states: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4. fsm is the registered state.
- Transitions:
  - IDLE→START on acceptance.
  - START→DATA when cycle_counter==CPB-1.
  - DATA→PARITY (PARITY≠0) or DATA→STOP (PARITY==0) when cycle_counter==CPB-1 and bit_counter==PAYLOAD_BITS-1.
  - PARITY→STOP when cycle_counter==CPB-1.
  - STOP→IDLE when cycle_counter==CPB-1 and stop_counter==STOP_BITS-1.
- Acceptance at edge k:
  - uart_tx_data is latched into a shift register.
  - The parity bit is computed from the latched word: even = XOR of data bits; odd = inverted XOR.
  - From edge k: state=START, uart_txd=0, busy=1.
- Line levels:
  - DATA: uart_txd drives shift register bit 0. The register shifts right once per completed bit period.
  - PARITY: uart_txd = parity bit.
  - STOP: uart_txd = 1.
- Each bit occupies exactly CPB cycles on uart_txd.
- uart_tx_busy = (state != IDLE).
- Busy frame length = (1 + PAYLOAD_BITS + (PARITY≠0) + STOP_BITS) × CPB cycles. Default: 40 cycles.
- While busy, uart_tx_en and uart_tx_data are ignored. There is no queuing; a request held across busy is taken on the first IDLE cycle.
- Back-to-back: with uart_tx_en held high, the next frame is accepted on the first IDLE cycle. Minimum line-high time between frames is STOP_BITS×CPB + 1 cycles.
- bit_counter (4 bits) and stop_counter are cleared in every state they do not count in.
- Reset:
  - resetn low at any edge, including mid-frame: uart_txd=1, busy=0, state=IDLE, counter=0, fsm=0, all counters and the shift register cleared.
  - The frame in progress is abandoned without a stop bit.
  - A request coinciding with reset is dropped.
- uart_txd never glitches low in IDLE.

Test Plan:
1. Reset, then default parameters, send 0xA5 → uart_txd is 0 for 4 cycles, then data bits 1,0,1,0,0,1,0,1 (LSB first, 4 cycles each), then 1 for 4 cycles. busy is high for exactly 40 cycles. fsm steps 1,2,4,0.
2. PARITY=2, send 0x07 → after the data bits, a parity bit of 1 for 4 cycles; frame is 44 cycles. With PARITY=1 the parity bit is 0.
3. STOP_BITS=2, send 0xFF → uart_txd is low only during the start bit (4 cycles); busy is high for 44 cycles.
4. Back-to-back: hold uart_tx_en high and present 0x12 then 0x34 → two correct frames with exactly 5 high cycles between the last data bit of frame 1 and the start bit of frame 2.
5. Change uart_tx_data to 0x00 and pulse uart_tx_en mid-frame while sending 0x3C → the line still carries 0x3C and no second frame starts.
6. Assert resetn low at cycle 17 of a frame → the next cycle has uart_txd=1, busy=0, fsm=0, counter=0. A new request after reset sends a full correct frame.
